window_popcount: RTL and testbench



---
 rtl/window_popcount_if.sv | 31 +++
 rtl/window_popcount.sv | 116 +++++++++++
 tb/tb_window_popcount.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/window_popcount_if.sv
// Bus bundle for window_popcount.
//   in_valid / in_data : word strobe and payload, driven by the source
//   clear              : synchronous flush request, driven by the source
//   ones / zeros       : number of ones / zeros currently in the window
//   full               : DEPTH words accepted since the last reset/clear
//   alarm              : hysteresis threshold flag
// master = data source / status consumer, slave = window_popcount.
interface window_popcount_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DATA_W * DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              clear;
  logic [CNT_W-1:0]  ones;
  logic [CNT_W-1:0]  zeros;
  logic              full;
  logic              alarm;

  modport master (
    output in_valid, in_data, clear,
    input  ones, zeros, full, alarm
  );

  modport slave (
    input  in_valid, in_data, clear,
    output ones, zeros, full, alarm
  );
endinterface

// File: rtl/window_popcount.sv
// Sliding-window bit counter.
// Keeps the last DEPTH accepted words and reports the ones/zeros they hold,
// a window-full flag and a hysteresis alarm (set at ones >= THR_HI, cleared
// at ones <= THR_LO).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : window_popcount_if slave (in_valid, in_data, clear in;
//           ones, zeros, full, alarm out)
// Pipeline: accept edge registers popcounts of the new and evicted word,
// next edge applies the incremental update to ones/full, the edge after
// that moves the alarm.
module window_popcount #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned THR_HI = 24,
  parameter int unsigned THR_LO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  window_popcount_if.slave bus
);

  localparam int unsigned TOTAL  = DATA_W * DEPTH;
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam int unsigned PC_W   = $clog2(DATA_W + 1);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  THR_HI_C = CNT_W'(THR_HI);
  localparam logic [CNT_W-1:0]  THR_LO_C = CNT_W'(THR_LO);
  localparam logic [FILL_W-1:0] DEPTH_C  = FILL_W'(DEPTH);

  typedef enum logic {IDLE, ARMED} state_e;

  function automatic logic [PC_W-1:0] popcnt(input logic [DATA_W-1:0] w);
    logic [PC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DATA_W; i++) n = n + PC_W'(w[i]);
    return n;
  endfunction

  logic [DATA_W-1:0] win_q [DEPTH];
  logic [DATA_W-1:0] win_d [DEPTH];
  logic [PC_W-1:0]   pc_new_q, pc_new_d;
  logic [PC_W-1:0]   pc_old_q, pc_old_d;
  logic              s1_vld_q, s1_vld_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  state_e            state_q, state_d;
  logic signed [CNT_W:0] sum;

  // Shift and stage-1 capture. The evicted word is read from win_q before
  // the shift, so shift and accumulate proceed independently each cycle.
  always_comb begin
    win_d    = win_q;
    pc_new_d = pc_new_q;
    pc_old_d = pc_old_q;
    s1_vld_d = bus.in_valid;
    if (bus.in_valid) begin
      win_d[0] = bus.in_data;
      for (int unsigned i = 1; i < DEPTH; i++) win_d[i] = win_q[i-1];
      pc_new_d = popcnt(bus.in_data);
      pc_old_d = popcnt(win_q[DEPTH-1]);
    end
  end

  // Incremental accumulate; the signed sum never leaves 0..TOTAL, so the
  // low CNT_W bits are the exact result.
  always_comb begin
    sum    = $signed({1'b0, ones_q})
           + $signed((CNT_W+1)'(pc_new_q))
           - $signed((CNT_W+1)'(pc_old_q));
    ones_d = ones_q;
    fill_d = fill_q;
    if (s1_vld_q) begin
      ones_d = sum[CNT_W-1:0];
      if (fill_q != DEPTH_C) fill_d = fill_q + 1'b1;
    end
  end

  // Alarm next state, evaluated on the registered count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ones_q >= THR_HI_C) state_d = ARMED;
      ARMED:   if (ones_q <= THR_LO_C) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      win_q    <= '{default: '0};
      pc_new_q <= '0;
      pc_old_q <= '0;
      s1_vld_q <= 1'b0;
      ones_q   <= '0;
      fill_q   <= '0;
      state_q  <= IDLE;
    end else begin
      win_q    <= win_d;
      pc_new_q <= pc_new_d;
      pc_old_q <= pc_old_d;
      s1_vld_q <= s1_vld_d;
      ones_q   <= ones_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
    end
  end

  assign bus.ones  = ones_q;
  assign bus.zeros = TOTAL_C - ones_q;
  assign bus.full  = (fill_q == DEPTH_C);
  assign bus.alarm = (state_q == ARMED);

endmodule

// File: tb/tb_window_popcount.sv
// Self-checking bench for window_popcount (DATA_W=8, DEPTH=4, THR 24/8).
// Reference model: the window is a queue of words, ones is recomputed from
// the whole queue, with the output latency applied edge by edge.
module tb_window_popcount;

  localparam int unsigned DW  = 8;
  localparam int unsigned DP  = 4;
  localparam int unsigned TOT = DW * DP;
  localparam int unsigned HI  = 24;
  localparam int unsigned LO  = 8;

  logic clk;
  logic rst_n;

  window_popcount_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  window_popcount #(
    .DATA_W(DW),
    .DEPTH (DP),
    .THR_HI(HI),
    .THR_LO(LO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total;
  int unsigned bad;

  // Model state
  logic [DW-1:0] m_win[$];
  int unsigned   m_fill;
  int unsigned   e_ones;
  bit            e_full;
  bit            e_alarm;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_win.delete();
    for (int i = 0; i < DP; i++) m_win.push_back('0);
    m_fill = 0;
  endtask

  // Drive one cycle, advance the model across the edge, then check.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit c, input bit r);
    bit          rs;
    int unsigned win_ones;
    int unsigned prev_ones;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.clear    = c;
    rst_n        = r;
    @(posedge clk);
    rs        = !r || c;
    prev_ones = e_ones;
    win_ones  = 0;
    foreach (m_win[i]) win_ones += $countones(m_win[i]);
    e_alarm = rs ? 1'b0 : (e_alarm ? (prev_ones > LO) : (prev_ones >= HI));
    e_full  = rs ? 1'b0 : (m_fill == DP);
    e_ones  = rs ? 0 : win_ones;
    if (rs) model_reset();
    else if (v) begin
      m_win.push_front(d);
      void'(m_win.pop_back());
      if (m_fill < DP) m_fill++;
    end
    #1;
    chk("ones",  bus.ones,  e_ones);
    chk("zeros", bus.zeros, TOT - e_ones);
    chk("full",  bus.full,  e_full);
    chk("alarm", bus.alarm, e_alarm);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    e_ones = 0; e_full = 0; e_alarm = 0;
    model_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clear    = 1'b0;
    rst_n        = 1'b0;

    // Reset
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("rst_zeros_const", bus.zeros, 32);

    // Fill with 0xFF, then drain with 0x00
    for (int i = 0; i < 4; i++) step(1, 8'hFF, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("fill_ones_const", bus.ones, 32);
    chk("fill_full_const", bus.full, 1);
    chk("fill_alarm_const", bus.alarm, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
    chk("drain_alarm_const", bus.alarm, 0);

    // Gaps after a fresh reset
    step(0, 8'h00, 0, 0);
    step(1, 8'h0F, 0, 1);
    step(0, 8'h00, 0, 1);
    step(1, 8'h03, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
    step(1, 8'h01, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("gap_ones_const", bus.ones, 7);
    chk("gap_full_const", bus.full, 0);

    // Clear with a word presented while ones=24 and alarm=1
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("pre_clr_alarm_const", bus.alarm, 1);
    step(1, 8'hFF, 1, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("clr_drop_const", bus.ones, 0);

    // Reset one edge after an accepted word
    step(1, 8'hFF, 0, 1);
    step(1, 8'hFF, 0, 1);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    chk("rst_mid_const", bus.ones, 0);

    // Random stream with dense/sparse phases and occasional clear/reset
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] d;
      bit dense;
      dense = ((i / 40) % 2) == 0;
      d = dense ? DW'($urandom | $urandom) : DW'($urandom & $urandom);
      step($urandom_range(0, 3) != 0, d,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 89) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
